fetch_controller: RTL and testbench

Program-counter and fetch-sequencing block placed directly upstream of `program_memory`. It drives the 5-bit instruction address and read strobe into the program memory and captures the returned instruction one cycle later. It buffers returned instructions in a small FIFO and presents them to the decode stage over a valid/ready handshake. It also handles branch redirects, discarding stale instructions and in-flight reads.

---
 rtl/fetch_controller.sv | 97 +++++++++
 tb/tb_fetch_controller.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_controller.sv
// Program-counter and fetch sequencer feeding decode from program_memory.
// Issues one read per cycle under a credit rule and buffers returns in a small FIFO.
module fetch_controller #(
    parameter int unsigned       ADDR_W     = 5,
    parameter int unsigned       DATA_W     = 32,
    parameter int unsigned       FIFO_DEPTH = 2,
    parameter logic [ADDR_W-1:0] RESET_PC   = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic              branch_valid,
    input  logic [ADDR_W-1:0] branch_target,
    output logic [ADDR_W-1:0] pm_address,
    output logic              pm_rd,
    input  logic [DATA_W-1:0] pm_inst,
    output logic              if_valid,
    input  logic              if_ready,
    output logic [DATA_W-1:0] if_inst,
    output logic [ADDR_W-1:0] if_pc
);

    localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] issued_addr;
    logic              pending;
    logic [CW-1:0]     count;
    logic [PW-1:0]     rd_ptr;
    logic [PW-1:0]     wr_ptr;
    logic [ADDR_W-1:0] fifo_pc   [FIFO_DEPTH];
    logic [DATA_W-1:0] fifo_inst [FIFO_DEPTH];

    logic              pop;
    logic              push;
    logic              issue;
    logic [CW:0]       occupancy;

    // Credit counts buffered entries plus the in-flight read, less this cycle's pop.
    always_comb begin
        if_valid  = (count != '0) && !branch_valid;
        pop       = if_valid && if_ready;
        push      = pending && !branch_valid;
        occupancy = (CW+1)'(count) + (CW+1)'(pending) - (CW+1)'(pop);
        issue     = rst_n && enable && !branch_valid
                    && (occupancy < (CW+1)'(FIFO_DEPTH));
    end

    assign pm_rd      = issue;
    assign pm_address = pc;
    assign if_inst    = fifo_inst[rd_ptr];
    assign if_pc      = fifo_pc[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc          <= RESET_PC;
            issued_addr <= '0;
            pending     <= 1'b0;
            count       <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
        end else if (branch_valid) begin
            pc      <= branch_target;
            pending <= 1'b0;
            count   <= '0;
            rd_ptr  <= '0;
            wr_ptr  <= '0;
        end else begin
            pending <= issue;
            if (issue) begin
                pc          <= pc + 1'b1;
                issued_addr <= pc;
            end
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            if (push && !pop)      count <= count + CW'(1);
            else if (!push && pop) count <= count - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                fifo_pc[i]   <= '0;
                fifo_inst[i] <= '0;
            end
        end else if (push) begin
            fifo_pc[wr_ptr]   <= issued_addr;
            fifo_inst[wr_ptr] <= pm_inst;
        end
    end

    fifo_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(push && !pop && count == CW'(FIFO_DEPTH)));

endmodule

// File: tb/tb_fetch_controller.sv
// Bench for fetch_controller: directed vector table, hand-written corner sequences,
// and randomized traffic checked against a queue-based reference model.
module tb_fetch_controller;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic        branch_valid;
    logic [4:0]  branch_target;
    logic [4:0]  pm_address;
    logic        pm_rd;
    logic [31:0] pm_inst;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_inst;
    logic [4:0]  if_pc;

    int checks   = 0;
    int failures = 0;

    logic [31:0] mem [32];

    fetch_controller #(
        .ADDR_W(5), .DATA_W(32), .FIFO_DEPTH(2), .RESET_PC(5'd0)
    ) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable),
        .branch_valid(branch_valid), .branch_target(branch_target),
        .pm_address(pm_address), .pm_rd(pm_rd), .pm_inst(pm_inst),
        .if_valid(if_valid), .if_ready(if_ready),
        .if_inst(if_inst), .if_pc(if_pc)
    );

    always #5 clk = ~clk;

    // Synchronous-read program memory; garbage stands in for the undriven bus.
    always @(posedge clk) begin
        if (pm_rd) pm_inst <= mem[pm_address];
        else       pm_inst <= 32'hDEAD_BEEF;
    end

    typedef struct {
        logic       en;
        logic       rdy;
        logic       bv;
        logic [4:0] tgt;
        logic       rd;
        logic [4:0] addr;
        logic       valid;
        logic [4:0] vpc;
    } vec_t;

    function automatic vec_t mk(bit en, bit rdy, bit bv, int tgt,
                                bit rd, int addr, bit valid, int vpc);
        vec_t v;
        v.en = en; v.rdy = rdy; v.bv = bv; v.tgt = 5'(tgt);
        v.rd = rd; v.addr = 5'(addr); v.valid = valid; v.vpc = 5'(vpc);
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic step(input bit en, input bit rdy, input bit bv, input logic [4:0] tgt);
        @(negedge clk);
        enable = en; if_ready = rdy; branch_valid = bv; branch_target = tgt;
        #1;
    endtask

    task automatic do_reset;
        enable = 1'b0; if_ready = 1'b0; branch_valid = 1'b0; branch_target = '0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Reference model: FIFO contents as a queue of fetched PCs plus one in-flight read.
    int  q[$];
    int  m_pend, m_paddr, m_pc;

    vec_t tbl[17];

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = 32'h1000_0000 + 32'(i);

        tbl[0]  = mk(1,1,0, 0, 1, 0, 0, 0);
        tbl[1]  = mk(1,1,0, 0, 1, 1, 0, 0);
        tbl[2]  = mk(1,1,0, 0, 1, 2, 1, 0);
        tbl[3]  = mk(1,1,0, 0, 1, 3, 1, 1);
        tbl[4]  = mk(1,0,0, 0, 0, 4, 1, 2);
        tbl[5]  = mk(1,0,0, 0, 0, 4, 1, 2);
        tbl[6]  = mk(1,1,0, 0, 1, 4, 1, 2);
        tbl[7]  = mk(1,1,0, 0, 1, 5, 1, 3);
        tbl[8]  = mk(1,1,0, 0, 1, 6, 1, 4);
        tbl[9]  = mk(1,0,0, 0, 0, 7, 1, 5);
        tbl[10] = mk(1,0,1,20, 0, 7, 0, 0);
        tbl[11] = mk(1,1,0, 0, 1,20, 0, 0);
        tbl[12] = mk(1,1,0, 0, 1,21, 0, 0);
        tbl[13] = mk(1,1,0, 0, 1,22, 1,20);
        tbl[14] = mk(0,1,0, 0, 0,23, 1,21);
        tbl[15] = mk(0,1,0, 0, 0,23, 1,22);
        tbl[16] = mk(0,1,0, 0, 0,23, 0, 0);

        // Reset values
        enable = 1'b0; if_ready = 1'b0; branch_valid = 1'b0; branch_target = '0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_if_valid", 32'(if_valid), 32'd0);
        chk("rst_pm_rd", 32'(pm_rd), 32'd0);
        chk("rst_pm_address", 32'(pm_address), 32'd0);
        chk("rst_if_inst", if_inst, 32'd0);
        chk("rst_if_pc", 32'(if_pc), 32'd0);
        rst_n = 1'b1;

        // Directed table: streaming, backpressure, redirect to 20, enable drop
        for (int i = 0; i < 17; i++) begin
            step(tbl[i].en, tbl[i].rdy, tbl[i].bv, tbl[i].tgt);
            chk($sformatf("tbl%0d_pm_rd", i), 32'(pm_rd), 32'(tbl[i].rd));
            chk($sformatf("tbl%0d_pm_address", i), 32'(pm_address), 32'(tbl[i].addr));
            chk($sformatf("tbl%0d_if_valid", i), 32'(if_valid), 32'(tbl[i].valid));
            if (tbl[i].valid) begin
                chk($sformatf("tbl%0d_if_pc", i), 32'(if_pc), 32'(tbl[i].vpc));
                chk($sformatf("tbl%0d_if_inst", i), if_inst, 32'h1000_0000 + 32'(tbl[i].vpc));
            end
        end

        // Randomized traffic against the queue model
        do_reset();
        q.delete(); m_pend = 0; m_paddr = 0; m_pc = 0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            bit en, rdy, bv;
            int tgt, exp_valid, exp_pop, exp_rd;
            en  = ($urandom_range(0, 9) < 8);
            rdy = ($urandom_range(0, 9) < 7);
            bv  = ($urandom_range(0, 99) < 6);
            tgt = int'($urandom_range(0, 31));
            step(en, rdy, bv, 5'(tgt));

            exp_valid = (q.size() != 0 && !bv) ? 1 : 0;
            exp_pop   = (exp_valid != 0 && rdy) ? 1 : 0;
            exp_rd    = (en && !bv && (q.size() + m_pend - exp_pop < 2)) ? 1 : 0;
            chk("rnd_pm_rd", 32'(pm_rd), 32'(exp_rd));
            chk("rnd_pm_address", 32'(pm_address), 32'(m_pc));
            chk("rnd_if_valid", 32'(if_valid), 32'(exp_valid));
            if (exp_valid != 0) begin
                chk("rnd_if_pc", 32'(if_pc), 32'(q[0]));
                chk("rnd_if_inst", if_inst, mem[q[0]]);
            end

            if (bv) begin
                q.delete(); m_pend = 0; m_pc = tgt;
            end else begin
                if (exp_pop != 0) void'(q.pop_front());
                if (m_pend != 0) q.push_back(m_paddr);
                if (exp_rd != 0) begin
                    m_pend = 1; m_paddr = m_pc; m_pc = (m_pc + 1) % 32;
                end else begin
                    m_pend = 0;
                end
            end
        end

        // Wrap: redirect to 30, expect 30, 31, 0, 1 from R+3 onward
        step(1, 1, 1, 5'd30);
        chk("wrap_redirect_valid", 32'(if_valid), 32'd0);
        step(1, 1, 0, 5'd0);
        chk("wrap_r1_pm_rd", 32'(pm_rd), 32'd1);
        chk("wrap_r1_addr", 32'(pm_address), 32'd30);
        chk("wrap_r1_valid", 32'(if_valid), 32'd0);
        step(1, 1, 0, 5'd0);
        chk("wrap_r2_valid", 32'(if_valid), 32'd0);
        for (int k = 0; k < 4; k++) begin
            int epc;
            epc = (30 + k) % 32;
            step(1, 1, 0, 5'd0);
            chk($sformatf("wrap%0d_valid", k), 32'(if_valid), 32'd1);
            chk($sformatf("wrap%0d_pc", k), 32'(if_pc), 32'(epc));
            chk($sformatf("wrap%0d_inst", k), if_inst, 32'h1000_0000 + 32'(epc));
        end

        // Asynchronous reset between edges while streaming
        repeat (3) step(1, 1, 0, 5'd0);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_if_valid", 32'(if_valid), 32'd0);
        chk("arst_pm_rd", 32'(pm_rd), 32'd0);
        chk("arst_pm_address", 32'(pm_address), 32'd0);
        chk("arst_if_pc", 32'(if_pc), 32'd0);
        @(negedge clk);
        enable = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        step(0, 1, 0, 5'd0);
        chk("arst_post_valid", 32'(if_valid), 32'd0);
        step(1, 1, 0, 5'd0);
        chk("arst_restart_rd", 32'(pm_rd), 32'd1);
        chk("arst_restart_addr", 32'(pm_address), 32'd0);
        step(1, 1, 0, 5'd0);
        chk("arst_restart_valid0", 32'(if_valid), 32'd0);
        step(1, 1, 0, 5'd0);
        chk("arst_first_valid", 32'(if_valid), 32'd1);
        chk("arst_first_pc", 32'(if_pc), 32'd0);
        chk("arst_first_inst", if_inst, 32'h1000_0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
